// File: rtl/mem_stage_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_dmem_ctrl
//
// MEM-stage data-memory access controller. It turns a pipeline load or store
// into a req/ack transaction on the data-memory bus, generates byte enables
// and lane-replicated store data, and aligns and extends load data for the
// MEM/WB register. The pipeline is frozen through stall_MEM until the
// transaction completes or times out.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   When defined, misaligned half/word accesses skip the bus entirely and
//   report misalign_out for one cycle. When undefined, the low address bits
//   that would make the access misaligned are simply ignored.
//
// Ports:
//   clk_MEM        clock, rising edge
//   rst_MemWB      asynchronous active-high reset
//   mem_read_in    MEM-stage instruction is a load
//   mem_write_in   MEM-stage instruction is a store (wins if both are set)
//   funct3_in      access size/sign (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   addr_in        byte address
//   wdata_in       store data
//   dmem_req       bus request, held until the ack is taken
//   dmem_we        1 = write transaction
//   dmem_addr      word-aligned bus address
//   dmem_be        byte enables
//   dmem_wdata     lane-replicated store data
//   dmem_ack       single-cycle completion pulse
//   dmem_rdata     read word, valid with dmem_ack
//   stall_MEM      freeze upstream stages and MEM/WB enable
//   load_data_out  aligned/extended load result
//   bus_err_out    one-cycle pulse when an access timed out
//   misalign_out   one-cycle pulse on a misaligned access (macro only)
// ----------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_MEM,
    input  logic              rst_MemWB,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        funct3_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_MEM,
    output logic [31:0]       load_data_out,
    output logic              bus_err_out
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       loadData_q, loadData_d;
    logic              busErr_q, busErr_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic              misaligned;
`endif

    logic              access;
    logic [3:0]        beCalc;
    logic [31:0]       wdataCalc;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    assign access = mem_read_in | mem_write_in;

    // Pull the addressed byte or half out of the bus word and extend it.
    // funct3[2] selects zero-extension; sizes 1x (including the reserved
    // encodings) pass the whole word through.
    function automatic logic [31:0] extractLoad(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        byteSel = 8'(word >> {lane, 3'b000});
        halfSel = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extractLoad = {{24{byteSel[7]}}, byteSel};
            3'b100:  extractLoad = {24'h0, byteSel};
            3'b001:  extractLoad = {{16{halfSel[15]}}, halfSel};
            3'b101:  extractLoad = {16'h0, halfSel};
            default: extractLoad = word;
        endcase
    endfunction

    // Byte enables and lane-replicated store data derived straight from the
    // incoming instruction, so they are ready to be captured on the same edge
    // that launches the request. Loads get the same enables as stores.
    always_comb begin
        beCalc    = 4'hF;
        wdataCalc = wdata_in;
        case (funct3_in[1:0])
            2'b00: begin
                beCalc    = 4'b0001 << addr_in[1:0];
                wdataCalc = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                beCalc    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdataCalc = {2{wdata_in[15:0]}};
            end
            default: begin
                beCalc    = 4'hF;
                wdataCalc = wdata_in;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // A half needs addr[0]=0, a word (or reserved size) needs addr[1:0]=0.
    always_comb begin
        misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                     (funct3_in[1] && (addr_in[1:0] != 2'b00));
    end
`endif

    // Next-state and next-register logic. IDLE launches the transaction,
    // BUSY waits for the ack or the timeout limit (ack wins a tie), and DONE
    // is the single unstalled cycle in which MEM/WB captures the result.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        cnt_d      = cnt_q;
        loadData_d = loadData_q;
        busErr_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        loadData_d = 32'h0;
                    end else begin
`endif
                        state_d  = BUSY;
                        req_d    = 1'b1;
                        we_d     = mem_write_in;
                        addr_d   = {addr_in[ADDR_W-1:2], 2'b00};
                        be_d     = beCalc;
                        wdata_d  = wdataCalc;
                        lane_d   = addr_in[1:0];
                        funct3_d = funct3_in;
                        cnt_d    = 8'd0;
`ifdef MEM_MISALIGN_TRAP_EN
                    end
`endif
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        loadData_d = extractLoad(funct3_q, lane_q, dmem_rdata);
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d    = DONE;
                    req_d      = 1'b0;
                    busErr_d   = 1'b1;
                    loadData_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // All controller state. Reset clears everything, including the request,
    // without waiting for a clock edge.
    always_ff @(posedge clk_MEM or posedge rst_MemWB) begin
        if (rst_MemWB) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            cnt_q      <= 8'd0;
            loadData_q <= 32'h0;
            busErr_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            cnt_q      <= cnt_d;
            loadData_q <= loadData_d;
            busErr_q   <= busErr_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // In IDLE the stall follows the access request combinationally so the
    // pipeline freezes in the very cycle the access is seen. Reset forces it
    // low regardless of the inputs.
    always_comb begin
        stall_MEM = 1'b0;
        if (!rst_MemWB) begin
            case (state_q)
                IDLE:    stall_MEM = access;
                BUSY:    stall_MEM = 1'b1;
                default: stall_MEM = 1'b0;
            endcase
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign load_data_out = loadData_q;
    assign bus_err_out   = busErr_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_out  = misalign_q;
`endif

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- MEM-stage data-memory access controller. It sits upstream of the MEM/WB pipeline register and produces the load data that register captures.
- Converts a pipeline load or store into a req/ack transaction on the data-memory bus. Generates byte enables and store-data replication, and aligns and sign- or zero-extends load data.
- Holds the pipeline through stall_MEM until the transaction completes or times out.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in BUSY waiting for dmem_ack before the access is aborted with a bus error. Legal range 2..255.
- ADDR_W, 32: width of the byte address.

Ports:
- clk_MEM  in  1  clock; all state updates on the rising edge.
- rst_MemWB  in  1  reset, asynchronous, active-high.
- mem_read_in  in  1  current MEM-stage instruction is a load.
- mem_write_in  in  1  current MEM-stage instruction is a store.
- funct3_in  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. For stores, 000 sb, 001 sh, 010 sw.
- addr_in  in  ADDR_W  byte address (ALU result).
- wdata_in  in  32  store data (rs2).
- dmem_req  out  1  bus request; held until the ack is sampled.
- dmem_we  out  1  1 = write transaction.
- dmem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  bus completion, single-cycle pulse.
- dmem_rdata  in  32  read word, valid in the cycle dmem_ack=1.
- stall_MEM  out  1  freeze IF/ID/EX/MEM and hold MEM/WB enable low.
- load_data_out  out  32  aligned/extended load result to MEM/WB.
- bus_err_out  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset: asynchronous and active-high. While rst_MemWB=1:
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data_out, bus_err_out and the timeout counter are all 0.
  - stall_MEM=0.
  - A reset mid-transaction drops dmem_req immediately. A late ack after reset is ignored.
- Access definition:
  - access = mem_read_in | mem_write_in.
  - If both are asserted, the access is treated as a store.
- IDLE state:
  - stall_MEM = access, combinationally.
  - On a clock edge with access=1: capture the address, funct3, write data and access type; go to BUSY. In the same edge, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata become valid.
  - dmem_ack received in IDLE is ignored.
- BUSY state:
  - stall_MEM=1. Bus outputs are held stable.
  - The timeout counter increments every cycle.
  - Ack taken on an edge with dmem_ack=1:
    - dmem_req drops to 0 and the state goes to DONE.
    - For a load, load_data_out is registered from dmem_rdata, aligned and extended.
    - For a store, load_data_out is left unchanged.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 without an ack, go to DONE with bus_err_out=1 and load_data_out=0.
  - If the ack arrives in the same cycle as the timeout limit, the ack wins and there is no error.
- DONE state:
  - stall_MEM=0 for exactly one cycle, so MEM/WB captures load_data_out.
  - MEM-stage inputs are ignored; the next edge always returns to IDLE.
  - bus_err_out is asserted only in DONE. load_data_out holds until the next load completes.
- Latency: minimum 2 cycles from access to stall release (ack in the first BUSY cycle).
- Store lane generation (lane = captured addr[1:0]):
  - sb: be = 1<<lane; wdata = byte0 replicated into all 4 lanes.
  - sh: be = 4'b0011 << (lane[1]*2); wdata = halfword0 replicated into both halves.
  - sw: be = 4'hF.
- Load extraction (lane = captured addr[1:0]):
  - lb/lbu select byte[lane] from dmem_rdata.
  - lh/lhu select the half at lane[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Reserved funct3 (011, 110, 111): treated as a word access.
- Misalignment, macro off:
  - addr[0] is ignored for halfword accesses; addr[1:0] are ignored for word accesses.
  - The access proceeds normally.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN. Adds output port misalign_out (1 bit, reset 0).
- With the macro, a misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) issues no bus request:
  - IDLE goes directly to DONE.
  - misalign_out=1 for the DONE cycle; load_data_out=0.
  - Stores are suppressed (no write occurs).
- Without the macro, the misalign_out port is absent and the masking rules above apply.

Test Plan:
- lw at addr 0x100, ack on the 1st BUSY cycle, rdata 0xDEADBEEF -> dmem_addr=0x100, be=F, stall high 2 cycles, load_data_out=0xDEADBEEF in DONE.
- lb at addr 0x103, rdata 0x80112233 -> load_data_out=0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x102 -> 0x00008011.
- sb at addr 0x201, wdata 0x000000A5 -> dmem_we=1, be=4'b0010, dmem_wdata=0xA5A5A5A5. sh at 0x202, wdata 0x1234 -> be=4'b1100, wdata=0x12341234.
- Load with no ack, TIMEOUT_CYCLES=4 -> req held 4 cycles then drops, bus_err_out pulses 1 cycle, load_data_out=0, stall released.
- Reset asserted in BUSY with req=1 -> req/stall drop immediately without a clock. An ack pulse 1 cycle after reset release is ignored; state stays IDLE.
- MEM_MISALIGN_TRAP_EN defined, lw at 0x102 -> no dmem_req, misalign_out=1 for one cycle, load_data_out=0. Undefined -> access goes to 0x100 with be=F.
